bcd_digit_adder: RTL and testbench
==================================

Name: bcd_digit_adder

Overview:
- Adds two single-digit BCD operands (0-9) and produces a two-digit BCD sum (tens, units) plus an error flag for non-BCD inputs.
- Purely arithmetic leaf block with a registered output stage.
- Fed by digit sources (switches, counters, upstream BCD logic); drives display or next-digit logic.
- Only 00..18 is reachable, so the tens digit is always 0 or 1.

Parameters:
- none

Ports:
- clk   input   1  system clock; all state updates on rising edge
- rst   input   1  synchronous reset, active-high
- in0   input   4  BCD operand A, valid range 0-9
- in1   input   4  BCD operand B, valid range 0-9
- out0  output  4  units digit of sum, BCD 0-9
- out1  output  4  tens digit of sum, BCD 0 or 1 (upper 3 bits always 0)
- flag  output  1  error: at least one operand sampled was > 9

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high; no asynchronous reset.
- Reset:
  - On a rising clk edge with rst=1: out0=0, out1=0, flag=0.
  - rst has priority over the input sample taken on the same edge.
  - rst asserted mid-stream discards that edge's computation; the next edge with rst=0 resumes normally.
- Latency:
  - Inputs are sampled combinationally and results registered.
  - Outputs reflect in0/in1 present at the preceding rising edge (1-cycle latency).
  - New operands are accepted every cycle; no handshake, no stall.
  - Outputs hold between edges and change only on rising clk.
- Arithmetic (both operands 0-9):
  - Binary sum s = in0 + in1, 5 bits wide (0..18).
  - If s > 9: out1 = 1, out0 = s - 10 (equivalent to adding 6 and taking the low nibble).
  - Else: out1 = 0, out0 = s.
  - flag = 0.
- Error (either operand 10-15):
  - flag = 1; out0 = 0; out1 = 0.
  - Both operands invalid gives the same result.
  - flag is not sticky: it clears on the first valid sample.
- Boundaries:
  - 0+0 -> 0,0.
  - 9+0 -> 0,9 (largest single-digit result, no carry).
  - 5+5 -> 1,0 (smallest carry case).
  - 9+9 -> 1,8 (maximum).
  - 9+10 -> flag=1.
  - 15+15 -> flag=1, no wrap into a valid-looking result.
- Outputs are never X after the first reset edge. X/Z on inputs is not handled.

Test Plan:
- Reset: in0=7, in1=8, rst=1 for 2 cycles -> out1=0, out0=0, flag=0. Release rst -> next edge gives out1=1, out0=5, flag=0.
- Exhaustive valid sweep: in0, in1 each 0..9 (100 pairs), one per cycle -> each cycle later, out1*10+out0 == in0+in1, out0<=9, out1<=1, flag=0.
- Carry boundary: (4,5) -> 0,9; (5,5) -> 1,0; (9,9) -> 1,8; (0,0) -> 0,0; all flag=0.
- Invalid operands:
  - (10,3) -> flag=1, 0,0.
  - (3,12) -> flag=1.
  - (15,15) -> flag=1, 0,0.
  - Then (2,3) -> flag=0, 0,5 (flag not sticky).
- Full 4-bit sweep: in0, in1 0..15 -> flag==(in0>9 || in1>9) exactly; outputs 0 whenever flag=1.
- Latency/back-to-back: change operands every cycle (1,1),(9,8),(11,0),(6,7) -> outputs 0,2 / 1,7 / flag / 1,3 on consecutive cycles, each exactly one edge after its input. Assert rst in the middle -> zeros that cycle, stream resumes after.

Source files
------------

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder: sums two 0-9 operands into a registered two-digit BCD result.
// Any operand above 9 raises flag and forces both output digits to zero.
module bcd_digit_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic       flag
);

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= 4'd9);
  endfunction

  logic [4:0] sum_s;
  logic [4:0] wrap_s;
  logic [3:0] units_s;
  logic [3:0] tens_s;
  logic       err_s;

  // Combinational digit sum with decimal carry and operand validity check.
  always_comb begin
    err_s   = !(is_bcd(in0) && is_bcd(in1));
    sum_s   = {1'b0, in0} + {1'b0, in1};
    wrap_s  = sum_s - 5'd10;
    units_s = 4'd0;
    tens_s  = 4'd0;
    if (err_s) begin
      // Invalid operands must not leak a plausible-looking sum.
      units_s = 4'd0;
      tens_s  = 4'd0;
    end else if (sum_s > 5'd9) begin
      units_s = wrap_s[3:0];
      tens_s  = 4'd1;
    end else begin
      units_s = sum_s[3:0];
      tens_s  = 4'd0;
    end
  end

  // Output register; reset wins over the sample taken on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out0 <= 4'd0;
      out1 <= 4'd0;
      flag <= 1'b0;
    end else begin
      out0 <= units_s;
      out1 <= tens_s;
      flag <= err_s;
    end
  end

endmodule

// File: tb/tb_bcd_digit_adder.sv
// Randomized and directed self-checking bench for bcd_digit_adder against a decimal-arithmetic model.
module tb_bcd_digit_adder;

  logic       clk;
  logic       rst;
  logic [3:0] in0;
  logic [3:0] in1;
  logic [3:0] out0;
  logic [3:0] out1;
  logic       flag;

  int checks_cnt   = 0;
  int failures_cnt = 0;

  logic [8:0] prev_exp;
  logic       have_prev = 1'b0;

  bcd_digit_adder dut (
    .clk  (clk),
    .rst  (rst),
    .in0  (in0),
    .in1  (in1),
    .out0 (out0),
    .out1 (out1),
    .flag (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      failures_cnt++;
      $display("FAIL %s: got flag/tens/units=%h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal arithmetic, packed as {flag, tens, units}.
  function automatic logic [8:0] model(input int a, input int b);
    int s;
    int t;
    int u;
    logic [3:0] tens;
    logic [3:0] units;
    if (a > 9 || b > 9) return {1'b1, 8'd0};
    s = a + b;
    t = s / 10;
    u = s % 10;
    tens  = 4'(t);
    units = 4'(u);
    return {1'b0, tens, units};
  endfunction

  // Drive one operand pair, confirm outputs hold before the edge, then check one edge later.
  task automatic step(input int a, input int b, input logic r, input string tag);
    logic [8:0] exp;
    in0 = 4'(a);
    in1 = 4'(b);
    rst = r;
    #2;
    if (have_prev) check_val({tag, "_hold"}, {flag, out1, out0}, prev_exp);
    @(posedge clk);
    #1;
    exp = r ? 9'd0 : model(a, b);
    check_val(tag, {flag, out1, out0}, exp);
    prev_exp  = exp;
    have_prev = 1'b1;
  endtask

  initial begin
    in0 = 4'd0;
    in1 = 4'd0;
    rst = 1'b1;

    // Reset held with live operands, then release.
    step(7, 8, 1'b1, "reset0");
    step(7, 8, 1'b1, "reset1");
    step(7, 8, 1'b0, "reset_release");

    // Exhaustive valid sweep.
    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 10; b++)
        step(a, b, 1'b0, $sformatf("valid_%0d_%0d", a, b));

    // Carry boundaries.
    step(4, 5, 1'b0, "bnd_4_5");
    step(5, 5, 1'b0, "bnd_5_5");
    step(9, 9, 1'b0, "bnd_9_9");
    step(0, 0, 1'b0, "bnd_0_0");
    step(9, 0, 1'b0, "bnd_9_0");

    // Invalid operands and non-sticky flag.
    step(10, 3, 1'b0, "inv_10_3");
    step(3, 12, 1'b0, "inv_3_12");
    step(15, 15, 1'b0, "inv_15_15");
    step(9, 10, 1'b0, "inv_9_10");
    step(2, 3, 1'b0, "inv_clear_2_3");

    // Full 4-bit sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step(a, b, 1'b0, $sformatf("full_%0d_%0d", a, b));

    // Back-to-back stream with reset in the middle.
    step(1, 1, 1'b0, "b2b_1_1");
    step(9, 8, 1'b0, "b2b_9_8");
    step(11, 0, 1'b0, "b2b_11_0");
    step(6, 7, 1'b0, "b2b_6_7");
    step(4, 4, 1'b1, "b2b_rst");
    step(8, 3, 1'b0, "b2b_resume_8_3");
    step(12, 1, 1'b0, "b2b_resume_12_1");

    // Randomized operands with occasional reset.
    for (int i = 0; i < 300; i++) begin
      int a;
      int b;
      logic r;
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      r = ($urandom_range(0, 15) == 0);
      step(a, b, r, $sformatf("rand%0d_%0d_%0d_r%0d", i, a, b, r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule
